// File: rtl/spi_reg_bridge_if.sv
// Bus bundle between the SPI slave / register file and spi_reg_bridge.
// The bridge uses the slave modport; the driving side uses master.
interface spi_reg_bridge_if;
  logic        spi_cs_n;
  logic        frame_abort;
  logic        rx_data_ready;
  logic [15:0] rx_data;
  logic        tx_data_ready;
  logic [15:0] tx_data;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_req;
  logic [6:0]  rd_addr;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_timeout;
  logic        rx_overrun;
  logic        busy;

  modport slave (
    input  spi_cs_n, frame_abort, rx_data_ready, rx_data, rd_valid, rd_data,
    output tx_data_ready, tx_data, wr_en, wr_addr, wr_data, rd_req, rd_addr,
           rd_timeout, rx_overrun, busy
  );

  modport master (
    output spi_cs_n, frame_abort, rx_data_ready, rx_data, rd_valid, rd_data,
    input  tx_data_ready, tx_data, wr_en, wr_addr, wr_data, rd_req, rd_addr,
           rd_timeout, rx_overrun, busy
  );
endinterface

// File: rtl/spi_reg_bridge.sv
// Turns SPI command/data words into register reads and writes.
// Define SPI_BURST_EN for auto-incrementing burst transfers.
module spi_reg_bridge (
    input logic             clk,
    input logic             rst_n,
    spi_reg_bridge_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT_RD, DATA, DONE} state_t;

    state_t      state_q;
    logic        cs_meta_q, cs_sync_q;
    logic [6:0]  addr_q;
    logic        is_rd_q;
    logic [7:0]  tmo_cnt_q;
    logic        tx_data_ready_q, wr_en_q, rd_req_q, rd_timeout_q, rx_overrun_q;
    logic [15:0] tx_data_q, wr_data_q;
    logic [6:0]  wr_addr_q, rd_addr_q;

    logic frame_end;
    logic unused_cmd_bits;

    assign frame_end       = cs_sync_q | bus.frame_abort;
    assign unused_cmd_bits = ^bus.rx_data[14:7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cs_meta_q       <= 1'b1;
            cs_sync_q       <= 1'b1;
            addr_q          <= '0;
            is_rd_q         <= 1'b0;
            tmo_cnt_q       <= '0;
            tx_data_ready_q <= 1'b0;
            wr_en_q         <= 1'b0;
            rd_req_q        <= 1'b0;
            rd_timeout_q    <= 1'b0;
            rx_overrun_q    <= 1'b0;
            tx_data_q       <= '0;
            wr_data_q       <= '0;
            wr_addr_q       <= '0;
            rd_addr_q       <= '0;
        end else begin
            cs_meta_q       <= bus.spi_cs_n;
            cs_sync_q       <= cs_meta_q;
            tx_data_ready_q <= 1'b0;
            wr_en_q         <= 1'b0;
            rd_req_q        <= 1'b0;
            rd_timeout_q    <= 1'b0;
            rx_overrun_q    <= 1'b0;

            // Frame end outranks everything, so no pulse is scheduled for the next cycle.
            if (frame_end) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.rx_data_ready) begin
                            addr_q  <= bus.rx_data[6:0];
                            is_rd_q <= bus.rx_data[15];
                            if (bus.rx_data[15]) begin
                                rd_req_q  <= 1'b1;
                                rd_addr_q <= bus.rx_data[6:0];
                                tmo_cnt_q <= '0;
                                state_q   <= WAIT_RD;
                            end else begin
                                state_q <= DATA;
                            end
                        end
                    end
                    WAIT_RD: begin
                        if (bus.rx_data_ready) rx_overrun_q <= 1'b1;
                        if (bus.rd_valid) begin
                            tx_data_q       <= bus.rd_data;
                            tx_data_ready_q <= 1'b1;
                            state_q         <= DATA;
                        end else if (tmo_cnt_q == 8'hFF) begin
                            tx_data_q       <= 16'hDEAD;
                            tx_data_ready_q <= 1'b1;
                            rd_timeout_q    <= 1'b1;
                            state_q         <= DATA;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + 8'd1;
                        end
                    end
                    DATA: begin
                        if (bus.rx_data_ready) begin
                            if (!is_rd_q) begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= addr_q;
                                wr_data_q <= bus.rx_data;
                            end
`ifdef SPI_BURST_EN
                            addr_q <= addr_q + 7'd1;
                            if (is_rd_q) begin
                                rd_req_q  <= 1'b1;
                                rd_addr_q <= addr_q + 7'd1;
                                tmo_cnt_q <= '0;
                                state_q   <= WAIT_RD;
                            end
`else
                            state_q <= DONE;
`endif
                        end
                    end
                    DONE:    state_q <= DONE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.tx_data_ready = tx_data_ready_q;
    assign bus.tx_data       = tx_data_q;
    assign bus.wr_en         = wr_en_q;
    assign bus.wr_addr       = wr_addr_q;
    assign bus.wr_data       = wr_data_q;
    assign bus.rd_req        = rd_req_q;
    assign bus.rd_addr       = rd_addr_q;
    assign bus.rd_timeout    = rd_timeout_q;
    assign bus.rx_overrun    = rx_overrun_q;
    assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: expected pulses are queued with their
// cycle stamp and a negedge monitor checks every pulse the bridge emits.
module tb_spi_reg_bridge;

    logic clk = 1'b0;
    logic rst_n;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    spi_reg_bridge_if bus ();

    spi_reg_bridge dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse mask bits: 4 wr_en, 3 rd_req, 2 tx_data_ready, 1 rd_timeout, 0 rx_overrun
    localparam logic [4:0] M_WR  = 5'b10000;
    localparam logic [4:0] M_RD  = 5'b01000;
    localparam logic [4:0] M_TX  = 5'b00100;
    localparam logic [4:0] M_TO  = 5'b00010;
    localparam logic [4:0] M_OVR = 5'b00001;

    typedef struct {
        logic [4:0]  mask;
        int unsigned cyc;
        logic [6:0]  addr;
        logic [15:0] data;
    } ev_t;

    ev_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input logic [4:0] m, input int unsigned c,
                             input logic [6:0] a, input logic [15:0] d);
        ev_t e;
        e.mask = m; e.cyc = c; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        logic [4:0] m;
        ev_t e;
        if (rst_n) begin
            m = {bus.wr_en, bus.rd_req, bus.tx_data_ready, bus.rd_timeout, bus.rx_overrun};
            if (m != 5'b0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got mask %b expected none (cycle %0d)", m, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_mask", {27'd0, m}, {27'd0, e.mask});
                    chk("pulse_cycle", cyc, e.cyc);
                    if (e.mask[4]) begin
                        chk("wr_addr", {25'd0, bus.wr_addr}, {25'd0, e.addr});
                        chk("wr_data", {16'd0, bus.wr_data}, {16'd0, e.data});
                    end
                    if (e.mask[3]) chk("rd_addr", {25'd0, bus.rd_addr}, {25'd0, e.addr});
                    if (e.mask[2]) chk("tx_data", {16'd0, bus.tx_data}, {16'd0, e.data});
                end
            end
        end
    end

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] w, input logic abort);
        bus.rx_data       = w;
        bus.rx_data_ready = 1'b1;
        bus.frame_abort   = abort;
        tick(1);
        bus.rx_data_ready = 1'b0;
        bus.frame_abort   = 1'b0;
    endtask

    task automatic frame_start();
        bus.spi_cs_n = 1'b0;
        tick(3);
    endtask

    task automatic frame_stop(input string name);
        bus.spi_cs_n = 1'b1;
        tick(3);
        chk(name, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.spi_cs_n      = 1'b1;
        bus.frame_abort   = 1'b0;
        bus.rx_data_ready = 1'b0;
        bus.rx_data       = '0;
        bus.rd_valid      = 1'b0;
        bus.rd_data       = '0;
        tick(3);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_pulses", {27'd0, bus.wr_en, bus.rd_req, bus.tx_data_ready,
                           bus.rd_timeout, bus.rx_overrun}, 32'd0);
        chk("rst_tx_data", {16'd0, bus.tx_data}, 32'd0);
        chk("rst_wr_data", {16'd0, bus.wr_data}, 32'd0);
        chk("rst_addrs", {18'd0, bus.wr_addr, bus.rd_addr}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Single write
        frame_start();
        send(16'h0012, 1'b0);
        expect_ev(M_WR, cyc + 1, 7'h12, 16'hA5A5);
        send(16'hA5A5, 1'b0);
        chk("write_busy", {31'd0, bus.busy}, 32'd1);
        frame_stop("write_idle");

        // Read answered after a few cycles, then the dummy word
        frame_start();
        expect_ev(M_RD, cyc + 1, 7'h05, 16'h0);
        send(16'h8005, 1'b0);
        tick(2);
        bus.rd_valid = 1'b1;
        bus.rd_data  = 16'h1234;
        expect_ev(M_TX, cyc + 1, 7'h0, 16'h1234);
        tick(1);
        bus.rd_valid = 1'b0;
`ifdef SPI_BURST_EN
        expect_ev(M_RD, cyc + 1, 7'h06, 16'h0);
`endif
        send(16'h0000, 1'b0);
        frame_stop("read_idle");

        // Read timeout: counter clears on entry, fires 256 cycles later
        frame_start();
        expect_ev(M_RD, cyc + 1, 7'h10, 16'h0);
        expect_ev(M_TX | M_TO, cyc + 257, 7'h0, 16'hDEAD);
        send(16'h8010, 1'b0);
        tick(258);
        chk("timeout_busy", {31'd0, bus.busy}, 32'd1);
        frame_stop("timeout_idle");

        // Abort coinciding with the data word
        frame_start();
        send(16'h0020, 1'b0);
        send(16'h1111, 1'b1);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        tick(2);
        frame_stop("abort_idle");

        // Burst write wrapping 7F -> 00; single-word build ignores the second word
        frame_start();
        send(16'h007F, 1'b0);
        expect_ev(M_WR, cyc + 1, 7'h7F, 16'h0001);
        send(16'h0001, 1'b0);
`ifdef SPI_BURST_EN
        expect_ev(M_WR, cyc + 1, 7'h00, 16'h0002);
`endif
        send(16'h0002, 1'b0);
        tick(2);
        frame_stop("burst_idle");

        // Overrun in WAIT_RD; rd_valid afterwards proves WAIT_RD was kept
        frame_start();
        expect_ev(M_RD, cyc + 1, 7'h01, 16'h0);
        send(16'h8001, 1'b0);
        tick(1);
        expect_ev(M_OVR, cyc + 1, 7'h0, 16'h0);
        send(16'h5555, 1'b0);
        tick(1);
        chk("overrun_busy", {31'd0, bus.busy}, 32'd1);
        bus.rd_valid = 1'b1;
        bus.rd_data  = 16'hBEEF;
        expect_ev(M_TX, cyc + 1, 7'h0, 16'hBEEF);
        tick(1);
        bus.rd_valid = 1'b0;
        tick(1);
        frame_stop("overrun_idle");

        // Reset asserted mid-frame
        frame_start();
        expect_ev(M_RD, cyc + 1, 7'h33, 16'h0);
        send(16'h8033, 1'b0);
        tick(1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_rd_addr", {25'd0, bus.rd_addr}, 32'd0);
        chk("midrst_tx_data", {16'd0, bus.tx_data}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        chk("midrst_after_busy", {31'd0, bus.busy}, 32'd0);
        frame_stop("midrst_idle");

        tick(3);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
